// File: rtl/gpu_pkg.sv
// Shared opcode, instruction-field and dispatcher-state definitions for the
// framebuffer instruction path.
package gpu_pkg;

  localparam logic [7:0] OP_NOP        = 8'h00;
  localparam logic [7:0] OP_SET_CURSOR = 8'h01;
  localparam logic [7:0] OP_PUT_PIXEL  = 8'h02;
  localparam logic [7:0] OP_FILL       = 8'h03;
  localparam logic [7:0] OP_CLEAR      = 8'h04;

  localparam int OPC_LSB  = 0;
  localparam int ARGC_LSB = 8;
  localparam int ARGB_LSB = 16;
  localparam int ARGA_LSB = 24;

  // Field order matches the bit positions above (arg_a is the MSB byte).
  typedef struct packed {
    logic [7:0] arg_a;
    logic [7:0] arg_b;
    logic [7:0] arg_c;
    logic [7:0] opcode;
  } instr_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DECODE,
    ST_WRITE,
    ST_RELEASE
  } disp_state_e;

  function automatic instr_t unpack_instr(input logic [31:0] w);
    instr_t r;
    r.opcode = w[OPC_LSB  +: 8];
    r.arg_c  = w[ARGC_LSB +: 8];
    r.arg_b  = w[ARGB_LSB +: 8];
    r.arg_a  = w[ARGA_LSB +: 8];
    return r;
  endfunction

endpackage

// File: rtl/cursor_tracker.sv
// Framebuffer cursor: x/y position plus linear address, kept in step
// incrementally so the per-pixel advance needs no multiplier.
module cursor_tracker #(
  parameter int H_RES  = 160,
  parameter int V_RES  = 120,
  parameter int ADDR_W = 15,
  parameter int X_W    = $clog2(H_RES),
  parameter int Y_W    = $clog2(V_RES)
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_clear,
  input  logic              i_load,
  input  logic [X_W-1:0]    i_x,
  input  logic [Y_W-1:0]    i_y,
  input  logic              i_advance,
  output logic [ADDR_W-1:0] o_addr
);

  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] load_addr;

  // Multiply only on an explicit load, never on the advance path.
  assign load_addr = ADDR_W'(i_y) * ADDR_W'(H_RES) + ADDR_W'(i_x);

  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    addr_d = addr_q;
    if (i_clear) begin
      x_d    = '0;
      y_d    = '0;
      addr_d = '0;
    end else if (i_load) begin
      x_d    = i_x;
      y_d    = i_y;
      addr_d = load_addr;
    end else if (i_advance) begin
      if (x_q == X_W'(H_RES - 1)) begin
        x_d = '0;
        if (y_q == Y_W'(V_RES - 1)) begin
          y_d    = '0;
          addr_d = '0;
        end else begin
          y_d    = y_q + 1'b1;
          addr_d = addr_q + 1'b1;
        end
      end else begin
        x_d    = x_q + 1'b1;
        addr_d = addr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      x_q    <= '0;
      y_q    <= '0;
      addr_q <= '0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      addr_q <= addr_d;
    end
  end

  assign o_addr = addr_q;

endmodule

// File: rtl/instruction_dispatcher.sv
// Decodes buffered 32-bit drawing instructions and sequences framebuffer pixel
// writes. Optional DISPATCH_VBLANK_SYNC_EN gates writes on i_vblank.
module instruction_dispatcher
  import gpu_pkg::*;
#(
  parameter int H_RES  = 160,
  parameter int V_RES  = 120,
  parameter int ADDR_W = 15,
  parameter int PIX_W  = 8
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_instr_ready,
  input  logic [31:0]       i_instruction,
  output logic              o_buf_release,
  output logic              o_fb_valid,
  input  logic              i_fb_ready,
`ifdef DISPATCH_VBLANK_SYNC_EN
  input  logic              i_vblank,
`endif
  output logic [ADDR_W-1:0] o_fb_addr,
  output logic [PIX_W-1:0]  o_fb_data,
  output logic              o_busy,
  output logic              o_err
);

  localparam int X_W   = $clog2(H_RES);
  localparam int Y_W   = $clog2(V_RES);
  localparam int CNT_W = (ADDR_W + 1 > 16) ? ADDR_W + 1 : 16;
  localparam logic [CNT_W-1:0] FRAME_PIX = CNT_W'(H_RES * V_RES);

  disp_state_e       state_q, state_d;
  instr_t            instr_q, instr_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic              skip_q, skip_d;

  logic              cur_clear, cur_load, cur_adv;
  logic              err;
  logic              wr_gate;
  logic              fire;
  logic [CNT_W-1:0]  fill_cnt;
  logic              xy_ok;

`ifdef DISPATCH_VBLANK_SYNC_EN
  assign wr_gate = i_vblank;
`else
  assign wr_gate = 1'b1;
`endif

  assign o_fb_valid = (state_q == ST_WRITE) && wr_gate;
  assign fire       = o_fb_valid && i_fb_ready;
  assign fill_cnt   = CNT_W'({instr_q.arg_b, instr_q.arg_c});
  assign xy_ok      = (int'(instr_q.arg_a) < H_RES) && (int'(instr_q.arg_b) < V_RES);

  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    rem_d     = rem_q;
    skip_d    = 1'b0;
    cur_clear = 1'b0;
    cur_load  = 1'b0;
    cur_adv   = 1'b0;
    err       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Buffer ready lingers one cycle past its release; don't re-launch on it.
        if (i_instr_ready && !skip_q) begin
          instr_d = unpack_instr(i_instruction);
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        state_d = ST_RELEASE;
        case (instr_q.opcode)
          OP_NOP: ;
          OP_SET_CURSOR: begin
            if (xy_ok) cur_load = 1'b1;
            else       err      = 1'b1;
          end
          OP_PUT_PIXEL: begin
            rem_d   = CNT_W'(1);
            state_d = ST_WRITE;
          end
          OP_FILL: begin
            rem_d = fill_cnt;
            if (fill_cnt != '0) state_d = ST_WRITE;
          end
          OP_CLEAR: begin
            cur_clear = 1'b1;
            rem_d     = FRAME_PIX;
            state_d   = ST_WRITE;
          end
          default: err = 1'b1;
        endcase
      end
      ST_WRITE: begin
        if (fire) begin
          cur_adv = 1'b1;
          rem_d   = rem_q - 1'b1;
          if (rem_q == CNT_W'(1)) state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        skip_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
      instr_q <= '0;
      rem_q   <= '0;
      skip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      rem_q   <= rem_d;
      skip_q  <= skip_d;
    end
  end

  cursor_tracker #(
    .H_RES (H_RES),
    .V_RES (V_RES),
    .ADDR_W(ADDR_W),
    .X_W   (X_W),
    .Y_W   (Y_W)
  ) u_cursor (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .i_clear  (cur_clear),
    .i_load   (cur_load),
    .i_x      (X_W'(instr_q.arg_a)),
    .i_y      (Y_W'(instr_q.arg_b)),
    .i_advance(cur_adv),
    .o_addr   (o_fb_addr)
  );

  assign o_fb_data     = instr_q.arg_a[PIX_W-1:0];
  assign o_buf_release = (state_q == ST_RELEASE);
  assign o_busy        = (state_q != ST_IDLE);
  assign o_err         = err;

endmodule

// File: tb/tb_instruction_dispatcher.sv
// Directed, table-driven bench for instruction_dispatcher with a simple
// instruction-buffer model (ready held one cycle past the release pulse).
module tb_instruction_dispatcher;

  logic        i_clk;
  logic        i_reset_n;
  logic        i_instr_ready;
  logic [31:0] i_instruction;
  logic        o_buf_release;
  logic        o_fb_valid;
  logic        i_fb_ready;
  logic [14:0] o_fb_addr;
  logic [7:0]  o_fb_data;
  logic        o_busy;
  logic        o_err;
`ifdef DISPATCH_VBLANK_SYNC_EN
  logic        i_vblank;
`endif

  int n_cmp = 0;
  int n_err = 0;

  instruction_dispatcher dut (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_instr_ready(i_instr_ready),
    .i_instruction(i_instruction),
    .o_buf_release(o_buf_release),
    .o_fb_valid   (o_fb_valid),
    .i_fb_ready   (i_fb_ready),
`ifdef DISPATCH_VBLANK_SYNC_EN
    .i_vblank     (i_vblank),
`endif
    .o_fb_addr    (o_fb_addr),
    .o_fb_data    (o_fb_data),
    .o_busy       (o_busy),
    .o_err        (o_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] instr;
    int          mode;      // 0: fb always ready, 1: ready toggles
    int          exp_wr;
    int          exp_first;
    int          exp_last;
    logic [7:0]  exp_data;
    int          exp_err;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string nm, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int   wr = 0, ec = 0, rel = 0, rel_cyc = -1, first = -1, last = -1, nxt = 0;
    bit   order_ok = 1, stable_ok = 1, data_ok = 1, done = 0;
    logic pv = 0, pr = 0;
    logic [14:0] pa = '0;
    logic [7:0]  pd = '0;
    @(negedge i_clk);
    i_instruction = v.instr;
    i_instr_ready = 1'b1;
    for (int c = 0; c < 50000 && !done; c++) begin
      if (c > 0) @(negedge i_clk);
      i_fb_ready = (v.mode == 1) ? c[0] : 1'b1;
      #1;
      if (pv && !pr && o_fb_valid && (o_fb_addr != pa || o_fb_data != pd)) stable_ok = 0;
      if (o_fb_valid && i_fb_ready) begin
        if (wr == 0) first = int'(o_fb_addr);
        else if (int'(o_fb_addr) != nxt) order_ok = 0;
        last = int'(o_fb_addr);
        nxt  = (last == 19199) ? 0 : last + 1;
        if (o_fb_data != v.exp_data) data_ok = 0;
        wr++;
      end
      if (o_err) ec++;
      if (o_buf_release) begin
        rel++;
        rel_cyc = c;
        done    = 1;
      end
      pv = o_fb_valid; pr = i_fb_ready; pa = o_fb_addr; pd = o_fb_data;
    end
    // Buffer ready falls one cycle after its release pulse.
    @(negedge i_clk);
    #1;
    if (o_buf_release || o_err) rel++;
    @(negedge i_clk);
    i_instr_ready = 1'b0;
    i_fb_ready    = 1'b0;
    #1;
    chk({nm, "_writes"}, wr, v.exp_wr);
    if (v.exp_wr > 0) begin
      chk({nm, "_first_addr"}, first, v.exp_first);
      chk({nm, "_last_addr"}, last, v.exp_last);
      chk({nm, "_data"}, int'(data_ok), 1);
      chk({nm, "_addr_order"}, int'(order_ok), 1);
      chk({nm, "_stall_stable"}, int'(stable_ok), 1);
    end
    chk({nm, "_err_pulses"}, ec, v.exp_err);
    chk({nm, "_release_pulses"}, rel, 1);
    if (v.mode == 0) chk({nm, "_release_cycle"}, rel_cyc, 2 + v.exp_wr);
    chk({nm, "_idle_after"}, int'(o_busy), 0);
  endtask

  initial begin
    int wr;
    int rel;
    vec_t v;

    tbl[0]  = '{32'h0A02_0001, 0, 0,     0,     0,     8'h00, 0}; // SET_CURSOR(10,2)
    tbl[1]  = '{32'h3C00_0002, 0, 1,     330,   330,   8'h3C, 0}; // PUT_PIXEL
    tbl[2]  = '{32'h9F77_0001, 0, 0,     0,     0,     8'h00, 0}; // SET_CURSOR(159,119)
    tbl[3]  = '{32'h0700_0303, 0, 3,     19199, 1,     8'h07, 0}; // FILL 3, wraps
    tbl[4]  = '{32'h5500_0002, 0, 1,     2,     2,     8'h55, 0}; // cursor at (2,0)
    tbl[5]  = '{32'hA000_0001, 0, 0,     0,     0,     8'h00, 1}; // x=160 rejected
    tbl[6]  = '{32'h0000_007F, 0, 0,     0,     0,     8'h00, 1}; // illegal opcode
    tbl[7]  = '{32'h1100_0002, 0, 1,     3,     3,     8'h11, 0}; // cursor unchanged
    tbl[8]  = '{32'h2200_0003, 0, 0,     0,     0,     8'h00, 0}; // FILL count 0
    tbl[9]  = '{32'h0000_0000, 0, 0,     0,     0,     8'h00, 0}; // NOP
    tbl[10] = '{32'h0000_0004, 1, 19200, 0,     19199, 8'h00, 0}; // CLEAR, stalls
    tbl[11] = '{32'h9900_0002, 0, 1,     0,     0,     8'h99, 0}; // wrapped to 0
    tbl[12] = '{32'h0078_0001, 0, 0,     0,     0,     8'h00, 1}; // y=120 rejected
    tbl[13] = '{32'hA501_0203, 1, 258,   1,     258,   8'hA5, 0}; // FILL 258, stalls

    i_reset_n     = 1'b0;
    i_instr_ready = 1'b0;
    i_instruction = '0;
    i_fb_ready    = 1'b0;
`ifdef DISPATCH_VBLANK_SYNC_EN
    i_vblank      = 1'b1;
`endif
    #2;
    chk("rst_release", int'(o_buf_release), 0);
    chk("rst_valid", int'(o_fb_valid), 0);
    chk("rst_addr", int'(o_fb_addr), 0);
    chk("rst_data", int'(o_fb_data), 0);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_err", int'(o_err), 0);
    repeat (3) @(negedge i_clk);
    i_reset_n = 1'b1;

    for (int i = 0; i < 14; i++) run_vec(tbl[i], $sformatf("v%0d", i));

    // Reset in the middle of a FILL of 100 (cursor currently at 259).
    @(negedge i_clk);
    i_instruction = 32'h4400_6403;
    i_instr_ready = 1'b1;
    i_fb_ready    = 1'b1;
    wr = 0;
    for (int c = 0; c < 200 && wr < 40; c++) begin
      if (c > 0) @(negedge i_clk);
      #1;
      if (o_fb_valid && i_fb_ready) wr++;
    end
    @(negedge i_clk);
    #1;
    chk("midfill_valid_before_rst", int'(o_fb_valid), 1);
    i_reset_n = 1'b0;
    #1;
    chk("midfill_valid_async", int'(o_fb_valid), 0);
    chk("midfill_busy", int'(o_busy), 0);
    chk("midfill_addr", int'(o_fb_addr), 0);
    i_instr_ready = 1'b0;
    rel = 0;
    repeat (3) begin
      @(negedge i_clk);
      #1;
      if (o_buf_release) rel++;
    end
    i_reset_n = 1'b1;
    repeat (2) begin
      @(negedge i_clk);
      #1;
      if (o_buf_release) rel++;
    end
    chk("midfill_no_release", rel, 0);
    v = '{32'h1200_0002, 0, 1, 0, 0, 8'h12, 0};
    run_vec(v, "post_rst_put");

`ifdef DISPATCH_VBLANK_SYNC_EN
    // Writes are held off while i_vblank is low, then issued at the same address.
    begin
      int leak = 0;
      int got_addr = -1;
      @(negedge i_clk);
      i_vblank      = 1'b0;
      i_instruction = 32'h2100_0002;
      i_instr_ready = 1'b1;
      i_fb_ready    = 1'b1;
      repeat (6) begin
        @(negedge i_clk);
        #1;
        if (o_fb_valid) leak++;
      end
      chk("vblank_hold", leak, 0);
      i_vblank = 1'b1;
      for (int c = 0; c < 10 && got_addr < 0; c++) begin
        @(negedge i_clk);
        #1;
        if (o_fb_valid && i_fb_ready) got_addr = int'(o_fb_addr);
      end
      chk("vblank_resume_addr", got_addr, 1);
      repeat (3) @(negedge i_clk);
      i_instr_ready = 1'b0;
      repeat (2) @(negedge i_clk);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
